// File: rtl/secded_rd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : secded_rd_decoder
// Brief    : Hamming SECDED read-path decoder with a fixed-latency pipeline,
//            saturating SEC/DED counters and a sticky first-error address.
// Revision : 1.0 - initial release
// ============================================================================
module secded_rd_decoder #(
    parameter int D_W   = 32,
    parameter int A_W   = 2,
    parameter int P_W   = 6,
    parameter int C_W   = D_W + P_W + 1,
    parameter int LAT   = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_vld_i,
    input  logic [A_W-1:0]   rd_addr_i,
    input  logic [C_W-1:0]   rd_cw_i,
    input  logic             cnt_clr_i,
    output logic             rd_vld_o,
    output logic [A_W-1:0]   rd_addr_o,
    output logic [D_W-1:0]   rd_data_o,
    output logic [1:0]       rd_err_o,
    output logic [CNT_W-1:0] sec_cnt_o,
    output logic [CNT_W-1:0] ded_cnt_o,
    output logic [A_W-1:0]   err_addr_o,
    output logic             err_addr_vld_o
);

    localparam logic [1:0]       c_err_zero = 2'd0;
    localparam logic [1:0]       c_err_one  = 2'd1;
    localparam logic [1:0]       c_err_two  = 2'd2;
    localparam logic [P_W-1:0]   c_syn_max  = P_W'(C_W - 1);
    localparam logic [CNT_W-1:0] c_cnt_max  = '1;

    // Codeword index holding data bit d: the d-th non-power-of-two position.
    function automatic int f_data_pos(input int d);
        int k;
        int pos;
        k   = 0;
        pos = 0;
        for (int i = 1; i < C_W; i++) begin
            if ((i & (i - 1)) != 0) begin
                if (k == d) pos = i;
                k++;
            end
        end
        return pos;
    endfunction

    logic [P_W-1:0] w_syn;
    logic           w_par;
    logic [C_W-1:0] w_flip;
    logic [C_W-1:0] w_cw_fix;
    logic [1:0]     w_err;
    logic [D_W-1:0] w_data;

    always_comb begin
        w_syn = '0;
        for (int i = 1; i < C_W; i++) begin
            if (rd_cw_i[i]) w_syn = w_syn ^ P_W'(i);
        end
        w_par  = ^rd_cw_i;
        w_flip = '0;
        w_err  = c_err_zero;
        if (w_par) begin
            if (w_syn == '0) begin
                w_err = c_err_one;
            end else if (w_syn <= c_syn_max) begin
                w_err  = c_err_one;
                w_flip = C_W'(1) << w_syn;
            end else begin
                w_err = c_err_two;
            end
        end else if (w_syn != '0) begin
            w_err = c_err_two;
        end
        w_cw_fix = rd_cw_i ^ w_flip;
    end

    for (genvar gd = 0; gd < D_W; gd++) begin : g_extract
        localparam int c_pos = f_data_pos(gd);
        assign w_data[gd] = w_cw_fix[c_pos];
    end

    logic [LAT-1:0]           r_vld;
    logic [LAT-1:0][A_W-1:0]  r_addr;
    logic [LAT-1:0][D_W-1:0]  r_data;
    logic [LAT-1:0][1:0]      r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld  <= '0;
            r_addr <= '0;
            r_data <= '0;
            r_err  <= '0;
        end else begin
            r_vld[0] <= rd_vld_i;
            if (rd_vld_i) begin
                r_addr[0] <= rd_addr_i;
                r_data[0] <= w_data;
                r_err[0]  <= w_err;
            end
            for (int k = 1; k < LAT; k++) begin
                r_vld[k] <= r_vld[k-1];
                if (r_vld[k-1]) begin
                    r_addr[k] <= r_addr[k-1];
                    r_data[k] <= r_data[k-1];
                    r_err[k]  <= r_err[k-1];
                end
            end
        end
    end

    assign rd_vld_o  = r_vld[LAT-1];
    assign rd_addr_o = r_addr[LAT-1];
    assign rd_data_o = r_data[LAT-1];
    assign rd_err_o  = r_err[LAT-1];

    logic [CNT_W-1:0] r_sec_cnt;
    logic [CNT_W-1:0] r_ded_cnt;
    logic [A_W-1:0]   r_err_addr;
    logic             r_err_addr_vld;

    // Clear wins over a same-cycle output event, which is then lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sec_cnt      <= '0;
            r_ded_cnt      <= '0;
            r_err_addr     <= '0;
            r_err_addr_vld <= 1'b0;
        end else if (cnt_clr_i) begin
            r_sec_cnt      <= '0;
            r_ded_cnt      <= '0;
            r_err_addr_vld <= 1'b0;
        end else if (rd_vld_o && (rd_err_o != c_err_zero)) begin
            if (rd_err_o == c_err_one && r_sec_cnt != c_cnt_max) r_sec_cnt <= r_sec_cnt + 1'b1;
            if (rd_err_o == c_err_two && r_ded_cnt != c_cnt_max) r_ded_cnt <= r_ded_cnt + 1'b1;
            if (!r_err_addr_vld) begin
                r_err_addr     <= rd_addr_o;
                r_err_addr_vld <= 1'b1;
            end
        end
    end

    assign sec_cnt_o      = r_sec_cnt;
    assign ded_cnt_o      = r_ded_cnt;
    assign err_addr_o     = r_err_addr;
    assign err_addr_vld_o = r_err_addr_vld;

endmodule
`default_nettype wire

// File: tb/tb_secded_rd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_secded_rd_decoder
// Brief    : Directed self-checking bench for secded_rd_decoder (LAT=2),
//            with a CNT_W=4 twin sharing the inputs for saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_secded_rd_decoder;

    logic        clk;
    logic        rst;
    logic        rd_vld_i;
    logic [1:0]  rd_addr_i;
    logic [38:0] rd_cw_i;
    logic        cnt_clr_i;
    logic        rd_vld_o;
    logic [1:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic [1:0]  rd_err_o;
    logic [15:0] sec_cnt_o;
    logic [15:0] ded_cnt_o;
    logic [1:0]  err_addr_o;
    logic        err_addr_vld_o;

    logic        s_rd_vld_o;
    logic [1:0]  s_rd_addr_o;
    logic [31:0] s_rd_data_o;
    logic [1:0]  s_rd_err_o;
    logic [3:0]  s_sec_cnt_o;
    logic [3:0]  s_ded_cnt_o;
    logic [1:0]  s_err_addr_o;
    logic        s_err_addr_vld_o;

    int checks;
    int failures;

    secded_rd_decoder #(.D_W(32), .A_W(2), .P_W(6), .C_W(39), .LAT(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .rd_vld_i(rd_vld_i), .rd_addr_i(rd_addr_i), .rd_cw_i(rd_cw_i),
        .cnt_clr_i(cnt_clr_i), .rd_vld_o(rd_vld_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
        .rd_err_o(rd_err_o), .sec_cnt_o(sec_cnt_o), .ded_cnt_o(ded_cnt_o),
        .err_addr_o(err_addr_o), .err_addr_vld_o(err_addr_vld_o)
    );

    secded_rd_decoder #(.D_W(32), .A_W(2), .P_W(6), .C_W(39), .LAT(2), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .rd_vld_i(rd_vld_i), .rd_addr_i(rd_addr_i), .rd_cw_i(rd_cw_i),
        .cnt_clr_i(cnt_clr_i), .rd_vld_o(s_rd_vld_o), .rd_addr_o(s_rd_addr_o),
        .rd_data_o(s_rd_data_o), .rd_err_o(s_rd_err_o), .sec_cnt_o(s_sec_cnt_o),
        .ded_cnt_o(s_ded_cnt_o), .err_addr_o(s_err_addr_o), .err_addr_vld_o(s_err_addr_vld_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference encoder: data into non-power-of-two positions, then Hamming and overall parity.
    function automatic logic [38:0] enc(input logic [31:0] d);
        logic [38:0] cw;
        logic        p;
        int          k;
        cw = '0;
        k  = 0;
        for (int i = 1; i < 39; i++) begin
            if ((i & (i - 1)) != 0) begin
                cw[i] = d[k];
                k++;
            end
        end
        for (int j = 0; j < 6; j++) begin
            p = 1'b0;
            for (int i = 1; i < 39; i++) begin
                if (((i >> j) & 1) != 0) p = p ^ cw[i];
            end
            cw[1 << j] = p;
        end
        cw[0] = ^cw[38:1];
        return cw;
    endfunction

    task automatic do_read(input logic [1:0] a, input logic [38:0] cw, output logic early,
                           output logic vld, output logic [31:0] d, output logic [1:0] e,
                           output logic [1:0] ad);
        @(negedge clk);
        rd_vld_i = 1'b1; rd_addr_i = a; rd_cw_i = cw;
        @(negedge clk);
        rd_vld_i = 1'b0;
        early = rd_vld_o;
        @(negedge clk);
        vld = rd_vld_o; d = rd_data_o; e = rd_err_o; ad = rd_addr_o;
        @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk); cnt_clr_i = 1'b1;
        @(negedge clk); cnt_clr_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rd_vld_i = 1'b0; rd_addr_i = '0; rd_cw_i = '0; cnt_clr_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (rd_vld_o !== 1'b0) begin failures++; $display("FAIL rst_vld got=%b exp=0", rd_vld_o); end
        checks++; if (rd_data_o !== 32'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", rd_data_o); end
        checks++; if (rd_err_o !== 2'd0 || rd_addr_o !== 2'd0) begin failures++; $display("FAIL rst_err_addr got=%0d/%0d exp=0/0", rd_err_o, rd_addr_o); end
        checks++; if (sec_cnt_o !== 16'd0 || ded_cnt_o !== 16'd0) begin failures++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", sec_cnt_o, ded_cnt_o); end
        checks++; if (err_addr_o !== 2'd0 || err_addr_vld_o !== 1'b0) begin failures++; $display("FAIL rst_sticky got=%0d/%b exp=0/0", err_addr_o, err_addr_vld_o); end
    endtask

    task automatic test_clean();
        logic early, vld; logic [31:0] d; logic [1:0] e, ad;
        do_read(2'd2, enc(32'hDEADBEEF), early, vld, d, e, ad);
        checks++; if (early !== 1'b0) begin failures++; $display("FAIL clean_early_vld got=%b exp=0", early); end
        checks++; if (vld !== 1'b1) begin failures++; $display("FAIL clean_vld got=%b exp=1", vld); end
        checks++; if (d !== 32'hDEADBEEF) begin failures++; $display("FAIL clean_data got=%h exp=deadbeef", d); end
        checks++; if (e !== 2'd0 || ad !== 2'd2) begin failures++; $display("FAIL clean_err_addr got=%0d/%0d exp=0/2", e, ad); end
        checks++; if (sec_cnt_o !== 16'd0 || ded_cnt_o !== 16'd0 || err_addr_vld_o !== 1'b0) begin failures++; $display("FAIL clean_cnt got=%0d/%0d/%b exp=0/0/0", sec_cnt_o, ded_cnt_o, err_addr_vld_o); end
    endtask

    task automatic test_sec();
        logic early, vld; logic [31:0] d; logic [1:0] e, ad;
        logic [38:0] cw;
        cw = enc(32'h12345678);
        do_read(2'd1, cw ^ (39'd1 << 5), early, vld, d, e, ad);
        checks++; if (vld !== 1'b1 || d !== 32'h12345678 || e !== 2'd1) begin failures++; $display("FAIL sec5 got=%b/%h/%0d exp=1/12345678/1", vld, d, e); end
        checks++; if (sec_cnt_o !== 16'd1 || ded_cnt_o !== 16'd0) begin failures++; $display("FAIL sec5_cnt got=%0d/%0d exp=1/0", sec_cnt_o, ded_cnt_o); end
        checks++; if (err_addr_o !== 2'd1 || err_addr_vld_o !== 1'b1) begin failures++; $display("FAIL sec5_sticky got=%0d/%b exp=1/1", err_addr_o, err_addr_vld_o); end
        do_read(2'd0, cw ^ 39'd1, early, vld, d, e, ad);
        checks++; if (d !== 32'h12345678 || e !== 2'd1) begin failures++; $display("FAIL sec0 got=%h/%0d exp=12345678/1", d, e); end
        do_read(2'd3, cw ^ (39'd1 << 8), early, vld, d, e, ad);
        checks++; if (d !== 32'h12345678 || e !== 2'd1 || ad !== 2'd3) begin failures++; $display("FAIL sec8 got=%h/%0d/%0d exp=12345678/1/3", d, e, ad); end
        do_read(2'd2, cw ^ (39'd1 << 38), early, vld, d, e, ad);
        checks++; if (d !== 32'h12345678 || e !== 2'd1) begin failures++; $display("FAIL sec38 got=%h/%0d exp=12345678/1", d, e); end
        checks++; if (sec_cnt_o !== 16'd4 || err_addr_o !== 2'd1) begin failures++; $display("FAIL sec_total got=%0d/%0d exp=4/1", sec_cnt_o, err_addr_o); end
    endtask

    task automatic test_ded();
        logic early, vld; logic [31:0] d; logic [1:0] e, ad;
        logic [38:0] cw;
        cw = enc(32'hA5A5A5A5);
        // positions 5 and 9 carry data bits 1 and 4
        do_read(2'd3, cw ^ (39'd1 << 5) ^ (39'd1 << 9), early, vld, d, e, ad);
        checks++; if (d !== 32'hA5A5A5B7 || e !== 2'd2 || ad !== 2'd3) begin failures++; $display("FAIL ded got=%h/%0d/%0d exp=a5a5a5b7/2/3", d, e, ad); end
        checks++; if (ded_cnt_o !== 16'd1 || sec_cnt_o !== 16'd4) begin failures++; $display("FAIL ded_cnt got=%0d/%0d exp=1/4", ded_cnt_o, sec_cnt_o); end
        checks++; if (err_addr_o !== 2'd1 || err_addr_vld_o !== 1'b1) begin failures++; $display("FAIL ded_sticky got=%0d/%b exp=1/1", err_addr_o, err_addr_vld_o); end
        // odd flip count with syndrome 32^4^3 = 39, beyond the codeword
        do_read(2'd2, cw ^ (39'd1 << 32) ^ (39'd1 << 4) ^ (39'd1 << 3), early, vld, d, e, ad);
        checks++; if (d !== 32'hA5A5A5A4 || e !== 2'd2) begin failures++; $display("FAIL ded_syn39 got=%h/%0d exp=a5a5a5a4/2", d, e); end
        checks++; if (ded_cnt_o !== 16'd2) begin failures++; $display("FAIL ded_syn39_cnt got=%0d exp=2", ded_cnt_o); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d [8];
        logic [1:0]  exp_e [8];
        logic [31:0] got_d [8];
        logic [1:0]  got_e [8];
        logic [1:0]  got_a [8];
        logic [38:0] cw;
        int n, first, last;
        exp_e = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd0, 2'd2, 2'd1};
        for (int i = 0; i < 8; i++) exp_d[i] = 32'h13579BDF + 32'h01010101 * i;
        pulse_clr();
        n = 0; first = -1; last = -1;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    cw = enc(exp_d[i]);
                    if (exp_e[i] == 2'd1) cw = cw ^ (39'd1 << (10 + 3 * i));
                    if (exp_e[i] == 2'd2) cw = cw ^ 39'd6;
                    rd_vld_i = 1'b1; rd_addr_i = 2'(i); rd_cw_i = cw;
                end
                @(negedge clk);
                rd_vld_i = 1'b0;
            end
            begin
                for (int c = 0; c < 16; c++) begin
                    @(negedge clk);
                    if (rd_vld_o) begin
                        if (n < 8) begin got_d[n] = rd_data_o; got_e[n] = rd_err_o; got_a[n] = rd_addr_o; end
                        if (first < 0) first = c;
                        last = c;
                        n++;
                    end
                end
            end
        join
        checks++; if (n !== 8 || last - first !== 7) begin failures++; $display("FAIL b2b_count got=%0d span=%0d exp=8 span=7", n, last - first); end
        for (int i = 0; i < 8 && i < n; i++) begin
            checks++;
            if (got_d[i] !== exp_d[i] || got_e[i] !== exp_e[i] || got_a[i] !== 2'(i)) begin
                failures++;
                $display("FAIL b2b_out%0d got=%h/%0d/%0d exp=%h/%0d/%0d", i, got_d[i], got_e[i], got_a[i], exp_d[i], exp_e[i], i % 4);
            end
        end
        checks++; if (sec_cnt_o !== 16'd3 || ded_cnt_o !== 16'd2) begin failures++; $display("FAIL b2b_cnt got=%0d/%0d exp=3/2", sec_cnt_o, ded_cnt_o); end
        checks++; if (err_addr_o !== 2'd1 || err_addr_vld_o !== 1'b1) begin failures++; $display("FAIL b2b_sticky got=%0d/%b exp=1/1", err_addr_o, err_addr_vld_o); end
    endtask

    task automatic test_sat_clear();
        logic [38:0] cw;
        cw = enc(32'h0BADF00D) ^ 39'd1;
        pulse_clr();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rd_vld_i = 1'b1; rd_addr_i = 2'(i); rd_cw_i = cw;
        end
        @(negedge clk);
        rd_vld_i = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (sec_cnt_o !== 16'd20) begin failures++; $display("FAIL sat_wide got=%0d exp=20", sec_cnt_o); end
        checks++; if (s_sec_cnt_o !== 4'd15 || s_ded_cnt_o !== 4'd0) begin failures++; $display("FAIL sat_narrow got=%0d/%0d exp=15/0", s_sec_cnt_o, s_ded_cnt_o); end
        checks++; if (s_err_addr_o !== 2'd0 || s_err_addr_vld_o !== 1'b1) begin failures++; $display("FAIL sat_sticky got=%0d/%b exp=0/1", s_err_addr_o, s_err_addr_vld_o); end
        @(negedge clk);
        rd_vld_i = 1'b1; rd_addr_i = 2'd3; rd_cw_i = enc(32'h0) ^ (39'd3 << 10);
        @(negedge clk);
        rd_vld_i = 1'b0;
        @(negedge clk);
        checks++; if (rd_vld_o !== 1'b1 || rd_err_o !== 2'd2) begin failures++; $display("FAIL clr_evt got=%b/%0d exp=1/2", rd_vld_o, rd_err_o); end
        cnt_clr_i = 1'b1;
        @(negedge clk);
        cnt_clr_i = 1'b0;
        checks++; if (sec_cnt_o !== 16'd0 || ded_cnt_o !== 16'd0 || err_addr_vld_o !== 1'b0) begin failures++; $display("FAIL clr_prio got=%0d/%0d/%b exp=0/0/0", sec_cnt_o, ded_cnt_o, err_addr_vld_o); end
        @(negedge clk);
        checks++; if (s_sec_cnt_o !== 4'd0 || s_ded_cnt_o !== 4'd0 || s_err_addr_vld_o !== 1'b0 || ded_cnt_o !== 16'd0) begin failures++; $display("FAIL clr_hold got=%0d/%0d/%b/%0d exp=0/0/0/0", s_sec_cnt_o, s_ded_cnt_o, s_err_addr_vld_o, ded_cnt_o); end
    endtask

    task automatic test_reset_midflight();
        logic early, vld; logic [31:0] d; logic [1:0] e, ad;
        logic seen;
        @(negedge clk);
        rd_vld_i = 1'b1; rd_addr_i = 2'd3; rd_cw_i = enc(32'hFFFF0000) ^ 39'd1;
        @(negedge clk);
        rd_vld_i = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rd_vld_o) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL mid_rst_vld got=%b exp=0", seen); end
        checks++; if (rd_data_o !== 32'h0 || rd_err_o !== 2'd0 || rd_addr_o !== 2'd0) begin failures++; $display("FAIL mid_rst_out got=%h/%0d/%0d exp=0/0/0", rd_data_o, rd_err_o, rd_addr_o); end
        checks++; if (sec_cnt_o !== 16'd0 || ded_cnt_o !== 16'd0 || err_addr_o !== 2'd0 || err_addr_vld_o !== 1'b0) begin failures++; $display("FAIL mid_rst_stat got=%0d/%0d/%0d/%b exp=0/0/0/0", sec_cnt_o, ded_cnt_o, err_addr_o, err_addr_vld_o); end
        do_read(2'd1, enc(32'hCAFEF00D), early, vld, d, e, ad);
        checks++; if (early !== 1'b0 || vld !== 1'b1 || d !== 32'hCAFEF00D || ad !== 2'd1) begin failures++; $display("FAIL post_rst got=%b/%b/%h/%0d exp=0/1/cafef00d/1", early, vld, d, ad); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_clean();
        test_sec();
        test_ded();
        test_back_to_back();
        test_sat_clear();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
